// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, keeps one word read in flight and buffers returned words for decode. Optional FETCH_ALIGN_CHECK_EN.
// Latency: request accept -> instr_valid = memory latency + 1 cycle; one instruction per cycle with 1-cycle memory.
// Backpressure: instr_ready low fills the buffer; a new request is issued only if its word is sure to fit.

module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     wr_vld,
    input  logic [WIDTH-1:0]         wr_dat,
    input  logic                     rd_rdy,
    output logic                     rd_vld,
    output logic [WIDTH-1:0]         rd_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_pop;

    assign rd_vld = (count != '0);
    assign do_pop = rd_rdy & rd_vld;
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_vld && !flush) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Flush takes priority over a same-cycle push or pop.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_vld) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{AW{1'b0}}, wr_vld} - {{AW{1'b0}}, do_pop};
        end
    end
endmodule

module fetch_unit #(
    parameter int                      ADDRESS_SIZE = 32,
    parameter logic [ADDRESS_SIZE-1:0] RESET_PC     = 32'h0000_0000,
    parameter int                      FIFO_DEPTH   = 2,
    parameter logic [ADDRESS_SIZE-1:0] NOP_INSTR    = 32'h0000_0001
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic [ADDRESS_SIZE-1:0] mem_req_addr,
    input  logic                    mem_resp_valid,
    input  logic [ADDRESS_SIZE-1:0] mem_resp_data,
    output logic                    instr_valid,
    input  logic                    instr_ready,
    output logic [ADDRESS_SIZE-1:0] instruction,
    output logic [ADDRESS_SIZE-1:0] instr_pc,
    input  logic                    redirect_valid,
    input  logic [ADDRESS_SIZE-1:0] redirect_pc,
    output logic                    fetch_misaligned
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [ADDRESS_SIZE-1:0] pc;
        logic [ADDRESS_SIZE-1:0] dat;
    } entry_t;

    logic [ADDRESS_SIZE-1:0] pc;
    logic [ADDRESS_SIZE-1:0] tag_pc;
    logic                    outstanding;
    logic                    drop;
    logic                    halted;
    logic                    misaligned_q;

    logic                    resp_take;
    logic                    push;
    logic                    pop;
    logic                    accept;
    logic [CW-1:0]           count;
    logic [CW:0]             occ_next;
    logic                    buf_vld;
    entry_t                  push_dat;
    entry_t                  head;
    logic                    redir_bad;
    logic [ADDRESS_SIZE-1:0] redir_target;

`ifdef FETCH_ALIGN_CHECK_EN
    assign redir_bad    = (redirect_pc[1:0] != 2'b00);
    assign redir_target = redirect_pc;
`else
    assign redir_bad    = 1'b0;
    assign redir_target = redirect_pc & ~ADDRESS_SIZE'(3);
`endif

    // A response with nothing outstanding is a protocol error and is ignored.
    assign resp_take = mem_resp_valid & outstanding;
    assign push      = resp_take & ~drop & ~redirect_valid;
    assign pop       = buf_vld & instr_ready & ~redirect_valid;
    assign occ_next  = {1'b0, count} + {{CW{1'b0}}, push} - {{CW{1'b0}}, pop};

    assign mem_req_valid = ~reset & ~halted & ~redirect_valid
                         & (~outstanding | mem_resp_valid)
                         & (occ_next < (CW+1)'(FIFO_DEPTH));
    assign mem_req_addr  = pc;
    assign accept        = mem_req_valid & mem_req_ready;

    assign push_dat = '{pc: tag_pc, dat: mem_resp_data};

    fetch_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_buf (
        .clk    (clk),
        .reset  (reset),
        .flush  (redirect_valid),
        .wr_vld (push),
        .wr_dat (push_dat),
        .rd_rdy (instr_ready & ~redirect_valid),
        .rd_vld (buf_vld),
        .rd_dat (head),
        .count  (count)
    );

    assign instr_valid      = buf_vld;
    assign instruction      = buf_vld ? head.dat : NOP_INSTR;
    assign instr_pc         = buf_vld ? head.pc : '0;
    assign fetch_misaligned = misaligned_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc           <= RESET_PC;
            tag_pc       <= '0;
            outstanding  <= 1'b0;
            drop         <= 1'b0;
            halted       <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            if (accept) begin
                outstanding <= 1'b1;
                tag_pc      <= pc;
                pc          <= pc + ADDRESS_SIZE'(4);
            end else if (resp_take) begin
                outstanding <= 1'b0;
            end
            if (resp_take && drop) begin
                drop <= 1'b0;
            end
            // Redirect never coincides with accept; an unreturned read is marked for discard.
            if (redirect_valid) begin
                pc           <= redir_target;
                halted       <= redir_bad;
                misaligned_q <= redir_bad;
                if (outstanding && !mem_resp_valid) begin
                    drop <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle-exact vector table for streaming/stall/redirect, hand sequences for multi-cycle cases.
module tb_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0001;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_misaligned;

    fetch_unit dut (
        .clk              (clk),
        .reset            (reset),
        .mem_req_valid    (mem_req_valid),
        .mem_req_ready    (mem_req_ready),
        .mem_req_addr     (mem_req_addr),
        .mem_resp_valid   (mem_resp_valid),
        .mem_resp_data    (mem_resp_data),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .instruction      (instruction),
        .instr_pc         (instr_pc),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .fetch_misaligned (fetch_misaligned)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;
    int lat    = 1;
    int cyc    = 0;
    int due    = 0;
    logic        pend  = 1'b0;
    logic        stale = 1'b0;
    logic [31:0] pend_addr;
    logic [31:0] pop_pc[$];
    logic [31:0] pop_ins[$];
    logic [31:0] acc[$];

    logic        s_req;
    logic [31:0] s_addr;
    logic        s_iv;
    logic [31:0] s_ipc;
    logic [31:0] s_ins;
    logic        s_mis;

    typedef struct {
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_ipc;
    } vec_t;

    vec_t tbl[16];

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    function automatic vec_t mk(input logic rdy, input logic redir, input logic [31:0] rpc,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic e_iv, input logic [31:0] e_ipc);
        vec_t v;
        v.rdy = rdy; v.redir = redir; v.rpc = rpc;
        v.e_req = e_req; v.e_addr = e_addr; v.e_iv = e_iv; v.e_ipc = e_ipc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One cycle: memory model drives its response, outputs are snapshotted, then the clock advances.
    task automatic tick();
        if (pend && cyc >= due) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = stale ? 32'hBAD0_BAD0 : data_of(pend_addr);
            pend  = 1'b0;
            stale = 1'b0;
        end else begin
            mem_resp_valid = 1'b0;
            mem_resp_data  = '0;
        end
        #1;
        s_req  = mem_req_valid;
        s_addr = mem_req_addr;
        s_iv   = instr_valid;
        s_ipc  = instr_pc;
        s_ins  = instruction;
        s_mis  = fetch_misaligned;
        if (mem_req_valid && mem_req_ready) begin
            pend      = 1'b1;
            due       = cyc + lat;
            pend_addr = mem_req_addr;
            acc.push_back(mem_req_addr);
        end
        if (instr_valid && instr_ready && !redirect_valid && !reset) begin
            pop_pc.push_back(instr_pc);
            pop_ins.push_back(instruction);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        redirect_valid = 1'b0;
        instr_ready = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    task automatic clear_logs();
        pop_pc.delete();
        pop_ins.delete();
        acc.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int found;
        int n0;
        int cnt;
        logic [31:0] exp_pc;

        reset = 1'b1;
        mem_req_ready = 1'b1;
        mem_resp_valid = 1'b0;
        mem_resp_data = '0;
        instr_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        @(negedge clk);

        // Reset state
        do_reset(2);
        check("rst_req_vld", 32'(s_req), 0);
        check("rst_instr_vld", 32'(s_iv), 0);
        check("rst_instruction", s_ins, NOP);
        check("rst_instr_pc", s_ipc, 0);
        check("rst_misaligned", 32'(s_mis), 0);

        // Streaming, decode stall/release, redirect coinciding with response and pop
        tbl[0]  = mk(1, 0, 0,        1, 32'h000, 0, 0);
        tbl[1]  = mk(1, 0, 0,        1, 32'h004, 0, 0);
        tbl[2]  = mk(1, 0, 0,        1, 32'h008, 1, 32'h000);
        tbl[3]  = mk(1, 0, 0,        1, 32'h00C, 1, 32'h004);
        tbl[4]  = mk(0, 0, 0,        0, 32'h010, 1, 32'h008);
        tbl[5]  = mk(0, 0, 0,        0, 32'h010, 1, 32'h008);
        tbl[6]  = mk(0, 0, 0,        0, 32'h010, 1, 32'h008);
        tbl[7]  = mk(1, 0, 0,        1, 32'h010, 1, 32'h008);
        tbl[8]  = mk(1, 0, 0,        1, 32'h014, 1, 32'h00C);
        tbl[9]  = mk(1, 0, 0,        1, 32'h018, 1, 32'h010);
        tbl[10] = mk(1, 0, 0,        1, 32'h01C, 1, 32'h014);
        tbl[11] = mk(1, 1, 32'h200,  0, 32'h020, 1, 32'h018);
        tbl[12] = mk(1, 0, 0,        1, 32'h200, 0, 0);
        tbl[13] = mk(1, 0, 0,        1, 32'h204, 0, 0);
        tbl[14] = mk(1, 0, 0,        1, 32'h208, 1, 32'h200);
        tbl[15] = mk(1, 0, 0,        1, 32'h20C, 1, 32'h204);

        for (int i = 0; i < 16; i++) begin
            instr_ready    = tbl[i].rdy;
            redirect_valid = tbl[i].redir;
            redirect_pc    = tbl[i].rpc;
            tick();
            check($sformatf("v%0d_req_vld", i), 32'(s_req), 32'(tbl[i].e_req));
            check($sformatf("v%0d_req_addr", i), s_addr, tbl[i].e_addr);
            check($sformatf("v%0d_instr_vld", i), 32'(s_iv), 32'(tbl[i].e_iv));
            if (tbl[i].e_iv) begin
                check($sformatf("v%0d_instr_pc", i), s_ipc, tbl[i].e_ipc);
                check($sformatf("v%0d_instruction", i), s_ins, data_of(tbl[i].e_ipc));
            end else begin
                check($sformatf("v%0d_nop", i), s_ins, NOP);
            end
        end
        redirect_valid = 1'b0;
        instr_ready = 1'b1;

        // Redirect while a 3-cycle read is in flight: its word must be dropped
        pend = 1'b0;
        lat = 3;
        do_reset(2);
        clear_logs();
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            tick();
            if (acc.size() > 0 && acc[acc.size()-1] == 32'h8) found = 1;
        end
        check("t3_req8_seen", 32'(found), 1);
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        tick();
        check("t3_no_req_on_redirect", 32'(s_req), 0);
        redirect_valid = 1'b0;
        n0 = pop_pc.size();
        check("t3_pre_pops", 32'(n0), 2);
        repeat (15) tick();
        check("t3_post_pops", 32'(pop_pc.size() > n0 + 1), 1);
        if (pop_pc.size() > n0 + 1) begin
            check("t3_first_pc", pop_pc[n0], 32'h100);
            check("t3_first_ins", pop_ins[n0], data_of(32'h100));
            check("t3_second_pc", pop_pc[n0+1], 32'h104);
        end
        cnt = 0;
        foreach (pop_pc[k]) if (pop_pc[k] == 32'h8) cnt++;
        check("t3_dropped_8", 32'(cnt), 0);

        // Misaligned redirect
        pend = 1'b0;
        lat = 1;
        do_reset(2);
        clear_logs();
        repeat (4) tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h102;
        tick();
        redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        cnt = 0;
        tick();
        check("t5_flag_set", 32'(s_mis), 1);
        if (s_req) cnt++;
        repeat (4) begin
            tick();
            if (s_req) cnt++;
        end
        check("t5_halted_reqs", 32'(cnt), 0);
        check("t5_halted_iv", 32'(s_iv), 0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0;
        exp_pc = 32'h40;
`else
        exp_pc = 32'h100;
`endif
        n0 = pop_pc.size();
        tick();
        check("t5_flag", 32'(s_mis), 0);
        check("t5_req_vld", 32'(s_req), 1);
        check("t5_req_addr", s_addr, exp_pc);
        repeat (4) tick();
        check("t5_pops", 32'(pop_pc.size() > n0), 1);
        if (pop_pc.size() > n0) check("t5_first_pc", pop_pc[n0], exp_pc);

        // Reset with a read outstanding; its late response must be ignored
        pend = 1'b0;
        lat = 3;
        do_reset(2);
        tick();
        check("t6_req0", 32'(s_req), 1);
        reset = 1'b1;
        stale = pend;
        tick();
        tick();
        check("t6_rst_req_vld", 32'(s_req), 0);
        check("t6_rst_iv", 32'(s_iv), 0);
        check("t6_rst_ins", s_ins, NOP);
        check("t6_rst_ipc", s_ipc, 0);
        reset = 1'b0;
        clear_logs();
        tick();
        check("t6_restart_vld", 32'(s_req), 1);
        check("t6_restart_addr", s_addr, 32'h0);
        tick();
        check("t6_late_ignored", 32'(s_iv), 0);
        repeat (6) tick();
        check("t6_pops", 32'(pop_pc.size() > 0), 1);
        if (pop_pc.size() > 0) begin
            check("t6_first_pc", pop_pc[0], 32'h0);
            check("t6_first_ins", pop_ins[0], data_of(32'h0));
        end
        cnt = 0;
        foreach (pop_ins[k]) if (pop_ins[k] == 32'hBAD0_BAD0) cnt++;
        check("t6_no_stale", 32'(cnt), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
